exec_div_unit: RTL and testbench

- Iterative radix-2 integer divider for the RV64M execute stage.
- Covers DIV, DIVU, REM and REMU, plus the 32-bit W forms (DIVW, DIVUW, REMW, REMUW).
- Sits beside the single-cycle ALU. Decode dispatches to it through a valid/ready handshake; it returns a tagged result to writeback through a second valid/ready handshake.
- Results follow RISC-V semantics, including the divide-by-zero and signed-overflow special cases.

---
 rtl/exec_div_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_exec_div_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_div_unit.sv
// exec_div_unit: iterative radix-2 restoring divider for the RV64M execute stage.
// It handles DIV/DIVU/REM/REMU and their 32-bit W forms, with RISC-V results for
// divide-by-zero and signed overflow. Operations arrive through an in_valid/in_ready
// handshake. The tagged result leaves through an out_valid/out_ready handshake.
module exec_div_unit #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_is_w,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [1:0]        r_op;
    logic              r_is_w;
    logic [TAG_W-1:0]  r_tag;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quot;
    logic [XLEN-1:0]   r_div;
    logic [5:0]        r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_fix_wait;
    logic [XLEN-1:0]   r_out_data;
    logic [TAG_W-1:0]  r_out_tag;

    logic              w_accept;
    logic              w_signed;
    logic              w_sa;
    logic              w_sb;
    logic [31:0]       w_a_lo_neg;
    logic [31:0]       w_b_lo_neg;
    logic [XLEN-1:0]   w_a_neg;
    logic [XLEN-1:0]   w_b_neg;
    logic [XLEN-1:0]   w_a_ext;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_shortcut;
    logic [XLEN:0]     w_shift;
    logic [XLEN+1:0]   w_trial;
    logic              w_fits;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;
    logic [XLEN-1:0]   w_sel;
    logic [XLEN-1:0]   w_result;

    // Operand preparation from the latched operands: signs, magnitudes and special cases
    always_comb begin
        w_signed   = ~r_op[0];
        w_sa       = w_signed & (r_is_w ? r_a[31] : r_a[XLEN-1]);
        w_sb       = w_signed & (r_is_w ? r_b[31] : r_b[XLEN-1]);
        w_a_lo_neg = '0 - r_a[31:0];
        w_b_lo_neg = '0 - r_b[31:0];
        w_a_neg    = '0 - r_a;
        w_b_neg    = '0 - r_b;
        w_a_ext    = r_is_w ? {32'h0, r_a[31:0]} : r_a;
        w_a_mag    = r_is_w ? {32'h0, (w_sa ? w_a_lo_neg : r_a[31:0])}
                            : (w_sa ? w_a_neg : r_a);
        w_b_mag    = r_is_w ? {32'h0, (w_sb ? w_b_lo_neg : r_b[31:0])}
                            : (w_sb ? w_b_neg : r_b);
        w_div_zero = r_is_w ? (r_b[31:0] == 32'h0) : (r_b == '0);
        w_ovf      = w_signed &
                     (r_is_w ? ((r_a[31:0] == 32'h8000_0000) && (r_b[31:0] == 32'hFFFF_FFFF))
                             : ((r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == '1)));
        w_shortcut = w_div_zero | w_ovf;
    end

    // One restoring step: shift {rem,quot} left, trial-subtract the divisor magnitude
    always_comb begin
        w_shift = {r_rem, r_quot[XLEN-1]};
        w_trial = {1'b0, w_shift} - {2'b00, r_div};
        // A non-negative difference is always below the divisor, so bit XLEN is clear too
        w_fits  = ~w_trial[XLEN+1] & ~w_trial[XLEN];
    end

    // Sign correction, quotient/remainder select and W-form sign extension
    always_comb begin
        w_q_fix  = r_neg_q ? ('0 - r_quot) : r_quot;
        w_r_fix  = r_neg_r ? ('0 - r_rem) : r_rem;
        w_sel    = r_op[1] ? w_r_fix : w_q_fix;
        w_result = r_is_w ? {{(XLEN-32){w_sel[31]}}, w_sel[31:0]} : w_sel;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; flush returns to IDLE from any state
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid & ~flush;
                if (w_accept) begin
                    w_next = S_PREP;
                end
            end
            S_PREP: begin
                w_next = w_shortcut ? S_FIXUP : S_ITER;
            end
            S_ITER: begin
                if (r_cnt == 6'd0) begin
                    w_next = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (!r_fix_wait) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
    end

    // Datapath: operand capture, preparation, iteration and result registration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_is_w     <= 1'b0;
            r_tag      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_fix_wait <= 1'b0;
            r_out_data <= '0;
            r_out_tag  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= in_op;
                        r_is_w <= in_is_w;
                        r_tag  <= in_tag;
                        r_a    <= in_a;
                        r_b    <= in_b;
                    end
                end
                S_PREP: begin
                    // Shortcut results are final as loaded. They wait one extra cycle in
                    // FIXUP, so their accept-to-valid latency stays 3 cycles.
                    if (w_div_zero) begin
                        r_quot     <= '1;
                        r_rem      <= w_a_ext;
                        r_neg_q    <= 1'b0;
                        r_neg_r    <= 1'b0;
                        r_fix_wait <= 1'b1;
                    end else if (w_ovf) begin
                        r_quot     <= w_a_ext;
                        r_rem      <= '0;
                        r_neg_q    <= 1'b0;
                        r_neg_r    <= 1'b0;
                        r_fix_wait <= 1'b1;
                    end else begin
                        r_rem      <= '0;
                        // W dividends sit in the upper half, so the 32 shifts consume them
                        r_quot     <= r_is_w ? {w_a_mag[31:0], 32'h0} : w_a_mag;
                        r_div      <= w_b_mag;
                        r_cnt      <= r_is_w ? 6'd31 : 6'd63;
                        r_neg_q    <= w_sa ^ w_sb;
                        r_neg_r    <= w_sa;
                        r_fix_wait <= 1'b0;
                    end
                end
                S_ITER: begin
                    r_rem  <= w_fits ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
                    r_quot <= {r_quot[XLEN-2:0], w_fits};
                    r_cnt  <= r_cnt - 6'd1;
                end
                S_FIXUP: begin
                    if (r_fix_wait) begin
                        r_fix_wait <= 1'b0;
                    end else begin
                        r_out_data <= w_result;
                        r_out_tag  <= r_tag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data = r_out_data;
    assign out_tag  = r_out_tag;

endmodule

// File: tb/tb_exec_div_unit.sv
// Directed bench for exec_div_unit: table of operations with hand-computed results
// and latencies, plus sequences for backpressure, flush and mid-operation reset.
module tb_exec_div_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_is_w;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_tag;

    int checks = 0;
    int errors = 0;

    exec_div_unit #(.XLEN(64), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_is_w   (in_is_w),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Offer one operation and hold it until the accept edge
    task automatic issue(input vec_t v);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        in_op    = v.op;
        in_is_w  = v.w;
        in_a     = v.a;
        in_b     = v.b;
        in_tag   = v.tag;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = 64'hDEAD_BEEF_0BAD_F00D;
        in_b     = 64'h5555_AAAA_3333_CCCC;
        in_tag   = 5'h1F;
    endtask

    // Issue, then count cycles from the accept edge until out_valid
    task automatic run_op(input vec_t v, input string nm);
        int lat;
        issue(v);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(v.lat));
        chk({nm, " data"}, out_data, v.exp);
        chk({nm, " tag"}, {59'h0, out_tag}, {59'h0, v.tag});
    endtask

    // Take the result and confirm the unit is idle again one cycle later
    task automatic release_result(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " in_ready after take"}, {63'h0, in_ready}, 64'h1);
        chk({nm, " out_valid after take"}, {63'h0, out_valid}, 64'h0);
    endtask

    vec_t vecs[14];

    initial begin
        vec_t bp;
        vec_t bb;
        vec_t ab;
        int   seen;

        vecs[0]  = '{OP_DIV,  1'b1, 64'h11223344AADDEEFF, 64'h22331144BBCC00EE, 5'h01, 64'h0000000000000001, 34};
        vecs[1]  = '{OP_REM,  1'b1, 64'h11223344AADDEEFF, 64'h22331144BBCC00EE, 5'h02, 64'hFFFFFFFFEF11EE11, 34};
        vecs[2]  = '{OP_DIVU, 1'b0, 64'd100,              64'd7,                5'h03, 64'd14,               66};
        vecs[3]  = '{OP_REMU, 1'b0, 64'd100,              64'd7,                5'h04, 64'd2,                66};
        vecs[4]  = '{OP_DIV,  1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2,                5'h05, 64'hFFFFFFFFFFFFFFFD, 66};
        vecs[5]  = '{OP_REM,  1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2,                5'h06, 64'hFFFFFFFFFFFFFFFF, 66};
        vecs[6]  = '{OP_DIV,  1'b0, 64'h1234,             64'd0,                5'h07, 64'hFFFFFFFFFFFFFFFF, 3};
        vecs[7]  = '{OP_REM,  1'b1, 64'h0000000100000005, 64'd0,                5'h08, 64'h0000000000000005, 3};
        vecs[8]  = '{OP_DIVU, 1'b1, 64'd7,                64'h0000000100000000, 5'h09, 64'hFFFFFFFFFFFFFFFF, 3};
        vecs[9]  = '{OP_DIV,  1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'h0A, 64'h8000000000000000, 3};
        vecs[10] = '{OP_REM,  1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'h0C, 64'h0000000000000000, 3};
        vecs[11] = '{OP_DIV,  1'b1, 64'h0000000080000000, 64'h00000000FFFFFFFF, 5'h0D, 64'hFFFFFFFF80000000, 3};
        vecs[12] = '{OP_DIVU, 1'b1, 64'h00000000FFFFFFFE, 64'h1234567800000001, 5'h0E, 64'hFFFFFFFFFFFFFFFE, 34};
        vecs[13] = '{OP_REMU, 1'b1, 64'hDEADBEEF00000064, 64'hCAFE000000000007, 5'h10, 64'h0000000000000002, 34};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_is_w   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset in_ready", {63'h0, in_ready}, 64'h1);
        chk("reset out_valid", {63'h0, out_valid}, 64'h0);
        chk("reset out_data", out_data, 64'h0);
        chk("reset out_tag", {59'h0, out_tag}, 64'h0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        // Backpressure: result and tag held while writeback stalls
        bp = '{OP_DIVU, 1'b0, 64'd100, 64'd7, 5'h0B, 64'd14, 66};
        run_op(bp, "bp");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d out_valid", k), {63'h0, out_valid}, 64'h1);
            chk($sformatf("bp hold%0d data", k), out_data, 64'd14);
            chk($sformatf("bp hold%0d tag", k), {59'h0, out_tag}, 64'h0B);
            chk($sformatf("bp hold%0d in_ready", k), {63'h0, in_ready}, 64'h0);
        end
        release_result("bp");
        bb = '{OP_REMU, 1'b0, 64'd100, 64'd7, 5'h1C, 64'd2, 66};
        run_op(bb, "b2b");
        release_result("b2b");

        // Flush 10 cycles into ITER, with a competing in_valid that must be ignored
        ab = '{OP_DIVU, 1'b0, 64'd100, 64'd7, 5'h15, 64'd14, 66};
        issue(ab);
        repeat (11) @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = OP_DIVU;
        in_a     = 64'd9;
        in_b     = 64'd3;
        in_tag   = 5'h12;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush in_ready", {63'h0, in_ready}, 64'h1);
        chk("flush out_valid", {63'h0, out_valid}, 64'h0);
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1;
        end
        chk("flush no result and stays idle", 64'(seen), 64'h0);
        run_op(ab, "after flush");
        release_result("after flush");

        // Mid-operation reset returns all outputs to their reset values
        issue(ab);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst out_data", out_data, 64'h0);
        chk("rst out_tag", {59'h0, out_tag}, 64'h0);
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("rst no result", 64'(seen), 64'h0);
        run_op(ab, "after rst");
        release_result("after rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
